// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences an external combinational 1-bit shifter through
// 'amount' single-bit steps in the direction given by 'dir', then registers
// the final value on dataOut and pulses done for one cycle.
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the 'abort' input, which
// cancels an operation in progress without a done pulse or dataOut update.
module shift_sequencer #(
  parameter int size = 8,
  parameter int AW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dir,
  input  logic [AW-1:0]   amount,
  input  logic [size-1:0] dataIn,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic            abort,
`endif
  output logic [1:0]      shiftCode,
  output logic [size-1:0] shiftData,
  input  logic [size-1:0] shiftResult,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] dataOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t          state, stateNext;
  logic [size-1:0] work, workNext;
  logic [AW-1:0]   count, countNext;
  logic            dirReg, dirNext;
  logic [size-1:0] dataOutNext;

  // State and datapath registers; reset clears everything, overriding start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      work    <= '0;
      count   <= '0;
      dirReg  <= 1'b0;
      dataOut <= '0;
    end else begin
      state   <= stateNext;
      work    <= workNext;
      count   <= countNext;
      dirReg  <= dirNext;
      dataOut <= dataOutNext;
    end
  end

  // Next-state, datapath update and shifter drive.
  always_comb begin
    stateNext   = state;
    workNext    = work;
    countNext   = count;
    dirNext     = dirReg;
    dataOutNext = dataOut;
    shiftCode   = 2'b00;
    shiftData   = work;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          workNext  = dataIn;
          countNext = amount;
          dirNext   = dir;
          if (amount != '0) begin
            stateNext = SHIFT;
          end else begin
            // Zero-step request completes immediately with the operand itself.
            stateNext   = DONE;
            dataOutNext = dataIn;
          end
        end else begin
          stateNext = IDLE;
        end
      end

      SHIFT: begin
        shiftCode = dirReg ? 2'b10 : 2'b01;
        workNext  = shiftResult;
        countNext = count - AW'(1);
        if (count == AW'(1)) begin
          stateNext   = DONE;
          dataOutNext = shiftResult;
        end
`ifdef SHIFT_SEQ_ABORT_EN
        if (abort) begin
          stateNext   = IDLE;
          dataOutNext = dataOut;
        end
`endif
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Status flags decode directly from the state register.
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter size, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter AW, default 3, giving the shift-amount width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request a multi-bit shift.
REQ-006 The block SHALL have port dir, input, 1 bit: 0 = right, 1 = left; sampled with start.
REQ-007 The block SHALL have port amount, input, AW bits: number of 1-bit shift steps; sampled with start.
REQ-008 The block SHALL have port dataIn, input, size bits: operand; sampled with start.
REQ-009 The block SHALL have port shiftCode, output, 2 bits: code to the 1-bit shifter (00 pass, 01 right, 10 left).
REQ-010 The block SHALL have port shiftData, output, size bits: operand to the 1-bit shifter.
REQ-011 The block SHALL have port shiftResult, input, size bits: combinational result from the 1-bit shifter.
REQ-012 The block SHALL have port busy, output, 1 bit: high while shift steps are executing.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port dataOut, output, size bits: registered final result.
REQ-015 The block SHALL have port abort, input, 1 bit, present only when SHIFT_SEQ_ABORT_EN is defined.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, plus a size-bit work register and an AW-bit step counter.
REQ-017 In IDLE or DONE, start=1 SHALL load work <= dataIn, count <= amount and latch dir, then go to SHIFT if amount != 0, else to DONE.
REQ-018 In IDLE or DONE, start=0 SHALL go to or remain in IDLE.
REQ-019 In SHIFT, each cycle SHALL: drive shiftData = work and shiftCode = 01 (dir=0) or 10 (dir=1); set work <= shiftResult; decrement count; go to DONE when count == 1.
REQ-020 Outside SHIFT, shiftCode SHALL be 00 and shiftData SHALL equal work; code 11 SHALL never be driven.
REQ-021 busy SHALL be 1 exactly in SHIFT; start while busy SHALL be ignored, with no effect on work, count or dir.
REQ-022 done SHALL be 1 exactly in DONE (one cycle per accepted request).
REQ-023 dataOut SHALL update on DONE entry with the final work value and hold until the next DONE entry.
REQ-024 Latency: start sampled at edge 0 SHALL give done high in cycle N+1, N = amount (N=0 gives cycle 1).
REQ-025 Back-to-back: start during DONE SHALL be accepted with no idle cycle.
REQ-026 amount = 2^AW-1 (7 for default parameters) SHALL take 7 SHIFT cycles; no wrap or underflow of count.

Reset
REQ-027 rst=1 SHALL force IDLE and clear work, count, dir, dataOut, busy and done to 0 at the next edge, overriding start.
REQ-028 rst during SHIFT SHALL abandon the operation with no done pulse, and dataOut SHALL read 0.

Configuration
REQ-029 With macro SHIFT_SEQ_ABORT_EN defined, abort=1 in SHIFT SHALL go to IDLE at the next edge with no done pulse and dataOut unchanged; in other states abort SHALL be ignored; rst has priority.
REQ-030 Without SHIFT_SEQ_ABORT_EN, the abort port and its logic SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-031 Right shift: dataIn=8'b1001_0110, dir=0, amount=3 -> busy in cycles 1-3, done in cycle 4, dataOut=8'b0001_0010.
REQ-032 Left shift: dataIn=8'b1001_0110, dir=1, amount=2 -> done in cycle 3, dataOut=8'b0101_1000; shiftCode=10 throughout SHIFT.
REQ-033 Zero amount: dataIn=8'hA5, amount=0 -> busy never high, done in cycle 1, dataOut=8'hA5, shiftCode stays 00.
REQ-034 start ignored: start with 8'hFF, right by 7, then start with 8'h00 in cycle 2 -> dataOut=8'h01 in cycle 8, a single done pulse.
REQ-035 Reset mid-operation: rst in cycle 2 of a 5-step shift -> IDLE next cycle, no done pulse, dataOut=0, busy=0.
REQ-036 Abort (macro defined): abort in cycle 2 of a shift with a prior dataOut=8'h3C -> IDLE, no done pulse, dataOut stays 8'h3C.
